// File: rtl/ps2_rx_apb_fifo_if.sv
// APB slave bus bundle for the PS/2 keyboard port.
// The signal names follow the peripheral's published port list.
interface ps2_rx_apb_fifo_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/ps2_rx_apb_fifo.sv
// PS/2 receiver with glitch filter, frame checker, byte FIFO and a zero-wait APB register file.
// Received bytes are popped by reading DATA; errors are sticky until cleared through STATUS.
module ps2_rx_apb_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                clock,
  input  logic                reset,
  ps2_rx_apb_fifo_if.slave    apb,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       FILT_MAX = 4'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} rxState_t;

  logic [1:0]       ps2ClkSync_q, ps2DataSync_q;
  logic             filtClk_q, filtClk_d;
  logic [3:0]       filtCnt_q, filtCnt_d;
  rxState_t         state_q, state_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [10:0]      frame_q, frame_d;
  logic [TO_W-1:0]  toCnt_q, toCnt_d;
  logic             enable_q, irqEn_q;
  logic             overflow_q, parityErr_q, frameErr_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;

  logic       sampleEdge, syncData, timeoutHit, frameDone;
  logic       frameBad, parityBad, hasRoom, push, pop;
  logic       access, rdAcc, wrAcc, notEmpty, full;
  logic [1:0] regSel;
  logic [2:0] w1cClr;
  logic       setOv, setPe, setFe;
  logic       unusedBits;

  assign unusedBits = ^{apb.in_pprot, apb.in_paddr[31:4], apb.in_paddr[1:0],
                        apb.in_pwdata[31:5], apb.in_pstrb[3:1]};

  // Two-flop synchronisers; the line idles high so reset to 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      ps2ClkSync_q  <= 2'b11;
      ps2DataSync_q <= 2'b11;
    end else begin
      ps2ClkSync_q  <= {ps2ClkSync_q[0], ps2_clk};
      ps2DataSync_q <= {ps2DataSync_q[0], ps2_data};
    end
  end

  assign syncData = ps2DataSync_q[1];

  // The filtered clock only follows after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filtClk_d = filtClk_q;
    filtCnt_d = 4'd0;
    if (ps2ClkSync_q[1] != filtClk_q) begin
      if (filtCnt_q == FILT_MAX) begin
        filtClk_d = ps2ClkSync_q[1];
      end else begin
        filtCnt_d = filtCnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      filtClk_q <= 1'b1;
      filtCnt_q <= 4'd0;
    end else begin
      filtClk_q <= filtClk_d;
      filtCnt_q <= filtCnt_d;
    end
  end

  assign sampleEdge = enable_q & filtClk_q & ~filtClk_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= 4'd0;
      frame_q  <= 11'd0;
      toCnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      frame_q  <= frame_d;
      toCnt_q  <= toCnt_d;
    end
  end

  // Deframing FSM; the timeout counter only runs between edges of a frame in progress.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    frame_d    = frame_q;
    toCnt_d    = toCnt_q;
    timeoutHit = 1'b0;
    frameDone  = 1'b0;
    if (!enable_q) begin
      state_d  = IDLE;
      bitCnt_d = 4'd0;
      toCnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          toCnt_d = '0;
          if (sampleEdge) begin
            frame_d[0] = syncData;
            bitCnt_d   = 4'd1;
            state_d    = RECV;
          end
        end
        RECV: begin
          if (sampleEdge) begin
            frame_d[bitCnt_q] = syncData;
            bitCnt_d          = bitCnt_q + 4'd1;
            toCnt_d           = '0;
            if (bitCnt_q == 4'd10) state_d = CHECK;
          end else if (toCnt_q == TO_MAX) begin
            timeoutHit = 1'b1;
            state_d    = IDLE;
            bitCnt_d   = 4'd0;
            toCnt_d    = '0;
          end else begin
            toCnt_d = toCnt_q + 1'b1;
          end
        end
        CHECK: begin
          frameDone = 1'b1;
          state_d   = IDLE;
          bitCnt_d  = 4'd0;
        end
        default: begin
          state_d  = IDLE;
          bitCnt_d = 4'd0;
        end
      endcase
    end
  end

  assign access   = apb.in_psel & apb.in_penable;
  assign rdAcc    = access & ~apb.in_pwrite;
  assign wrAcc    = access & apb.in_pwrite & apb.in_pstrb[0];
  assign regSel   = apb.in_paddr[3:2];
  assign notEmpty = (count_q != '0);
  assign full     = (count_q == DEPTH_C);

  assign frameBad  = frame_q[0] | ~frame_q[10];
  assign parityBad = ~(^frame_q[9:1]);
  assign pop       = rdAcc & (regSel == 2'd0) & notEmpty;
  assign hasRoom   = ~full | pop;
  assign push      = frameDone & ~frameBad & ~parityBad & hasRoom;
  assign setOv     = frameDone & ~frameBad & ~parityBad & ~hasRoom;
  assign setPe     = frameDone & ~frameBad & parityBad;
  assign setFe     = (frameDone & frameBad) | timeoutHit;
  assign w1cClr    = (wrAcc && regSel == 2'd1) ? apb.in_pwdata[4:2] : 3'b000;

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr_q] <= frame_q[8:1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Sticky flags: a hardware set in the same cycle as a W1C clear takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      enable_q    <= 1'b1;
      irqEn_q     <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  & ~w1cClr[0]) | setOv;
      parityErr_q <= (parityErr_q & ~w1cClr[1]) | setPe;
      frameErr_q  <= (frameErr_q  & ~w1cClr[2]) | setFe;
      if (wrAcc && regSel == 2'd2) begin
        enable_q <= apb.in_pwdata[0];
        irqEn_q  <= apb.in_pwdata[1];
      end
    end
  end

  always_comb begin
    apb.in_prdata = 32'd0;
    if (access) begin
      unique case (regSel)
        2'd0:    apb.in_prdata = notEmpty ? {23'd0, 1'b1, mem[rdPtr_q]} : 32'd0;
        2'd1:    apb.in_prdata = {16'd0, 8'(count_q), 3'd0, frameErr_q, parityErr_q,
                                  overflow_q, full, notEmpty};
        2'd2:    apb.in_prdata = {30'd0, irqEn_q, enable_q};
        default: apb.in_prdata = 32'd0;
      endcase
    end
  end

  assign apb.in_pready  = access;
  assign apb.in_pslverr = access & (regSel == 2'd3);
  assign irq            = irqEn_q & notEmpty;

endmodule

// File: tb/tb_ps2_rx_apb_fifo.sv
// Bench for ps2_rx_apb_fifo: a simulated keyboard drives PS/2 frames while APB accesses
// are checked against a queue-based model of the receive FIFO and sticky flags.
module tb_ps2_rx_apb_fifo;

  localparam int DEPTH = 8;
  localparam int TOUT  = 20000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic irq;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] modelQ[$];
  bit modelOv, modelPe, modelFe, modelEn, modelIrqEn;

  ps2_rx_apb_fifo_if bus();

  ps2_rx_apb_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(TOUT)) dut (
    .clock(clock), .reset(reset), .apb(bus),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] expStatus();
    int n = modelQ.size();
    return {16'd0, 8'(n), 3'd0, modelFe, modelPe, modelOv, (n == DEPTH), (n != 0)};
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apbRead(input logic [31:0] addr, output logic [31:0] data,
                         output logic err, output logic rdy);
    @(negedge clock);
    bus.in_paddr = addr; bus.in_pwrite = 1'b0; bus.in_psel = 1'b1; bus.in_penable = 1'b0;
    bus.in_pstrb = 4'h0;
    @(negedge clock);
    bus.in_penable = 1'b1;
    #1;
    data = bus.in_prdata; err = bus.in_pslverr; rdy = bus.in_pready;
    @(negedge clock);
    bus.in_psel = 1'b0; bus.in_penable = 1'b0;
  endtask

  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(negedge clock);
    bus.in_paddr = addr; bus.in_pwrite = 1'b1; bus.in_pwdata = data; bus.in_pstrb = strb;
    bus.in_psel = 1'b1; bus.in_penable = 1'b0;
    @(negedge clock);
    bus.in_penable = 1'b1;
    @(negedge clock);
    bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pwrite = 1'b0;
  endtask

  // Device side: data changes mid-high, clock period 100 system clocks.
  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); ps2_data = bits[i];
      waitClk(25); ps2_clk = 1'b0;
      waitClk(50); ps2_clk = 1'b1;
      waitClk(25);
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit badPar, input bit badStop);
    return {~badStop, (~^b) ^ badPar, b, 1'b0};
  endfunction

  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop);
    sendBits(makeFrame(b, badPar, badStop), 11);
    waitClk(20);
    if (modelEn) begin
      if (badStop) modelFe = 1;
      else if (badPar) modelPe = 1;
      else if (modelQ.size() < DEPTH) modelQ.push_back(b);
      else modelOv = 1;
    end
  endtask

  function automatic logic [31:0] modelPop();
    if (modelQ.size() == 0) return 32'd0;
    return {23'd0, 1'b1, modelQ.pop_front()};
  endfunction

  task automatic doReset();
    @(negedge clock); reset = 1'b1;
    waitClk(3); reset = 1'b0;
    modelQ.delete(); modelOv = 0; modelPe = 0; modelFe = 0; modelEn = 1; modelIrqEn = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, r;
    testsRun++;
    if (irq !== 1'b0 || bus.in_prdata !== 32'd0 || bus.in_pslverr !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle irq=%b prdata=%h pslverr=%b want 0/0/0", irq, bus.in_prdata, bus.in_pslverr);
    end
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_status got %h want 0", d); end
    apbRead(32'h8, d, e, r); testsRun++;
    if (d !== 32'h1) begin testsFailed++; $display("[TB] FAIL reset_ctrl got %h want 1", d); end
    apbRead(32'h0, d, e, r); testsRun++;
    if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data got %h want 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d; logic e, r;
    sendFrame(8'h1C, 0, 0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0101) begin testsFailed++; $display("[TB] FAIL single_status got %h want 0101", d); end
    apbRead(32'h0, d, e, r); testsRun++;
    if (d !== {23'd0, 1'b1, 8'h1C}) begin testsFailed++; $display("[TB] FAIL single_data got %h want 11c", d); end
    void'(modelPop());
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== expStatus()) begin testsFailed++; $display("[TB] FAIL single_after got %h want %h", d, expStatus()); end
  endtask

  task automatic test_irq();
    logic [31:0] d, x; logic e, r;
    apbWrite(32'h8, 32'h3, 4'h1); modelIrqEn = 1;
    sendFrame(8'hF0, 0, 0);
    sendFrame(8'h1C, 0, 0);
    #1; testsRun++;
    if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL irq_set got %b want 1", irq); end
    for (int i = 0; i < 2; i++) begin
      apbRead(32'h0, d, e, r); x = modelPop(); #1; testsRun++;
      if (d !== x || irq !== (modelIrqEn && modelQ.size() != 0)) begin
        testsFailed++;
        $display("[TB] FAIL irq_read%0d data=%h irq=%b want %h/%b", i, d, irq, x, modelQ.size() != 0);
      end
    end
    apbWrite(32'h8, 32'h1, 4'h1); modelIrqEn = 0;
  endtask

  task automatic test_overflow();
    logic [31:0] d, x; logic e, r;
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 0, 0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0807 || d !== expStatus()) begin
      testsFailed++; $display("[TB] FAIL ovf_status got %h want 0807", d);
    end
    for (int i = 1; i <= 9; i++) begin
      apbRead(32'h0, d, e, r); x = modelPop(); testsRun++;
      if (d !== x) begin testsFailed++; $display("[TB] FAIL ovf_read%0d got %h want %h", i, d, x); end
    end
    apbWrite(32'h4, 32'h4, 4'h1); modelOv = 0;
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL ovf_clear got %h want 0", d); end
  endtask

  task automatic test_parity();
    logic [31:0] d; logic e, r;
    sendFrame(8'h1C, 1, 0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0008) begin testsFailed++; $display("[TB] FAIL parity_status got %h want 0008", d); end
    apbWrite(32'h4, 32'h8, 4'h0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0008) begin testsFailed++; $display("[TB] FAIL parity_nostrb got %h want 0008", d); end
    apbWrite(32'h4, 32'h8, 4'h1); modelPe = 0;
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL parity_clear got %h want 0", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d, x; logic e, r;
    sendBits(makeFrame(8'hA5, 0, 0), 4);
    waitClk(TOUT + 10); modelFe = 1;
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0010) begin testsFailed++; $display("[TB] FAIL timeout_status got %h want 0010", d); end
    sendFrame(8'h5A, 0, 0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0111) begin testsFailed++; $display("[TB] FAIL timeout_next_status got %h want 0111", d); end
    apbRead(32'h0, d, e, r); x = modelPop(); testsRun++;
    if (d !== x || d !== 32'h15A) begin testsFailed++; $display("[TB] FAIL timeout_next_data got %h want 15a", d); end
    apbWrite(32'h4, 32'h1C, 4'h1); modelFe = 0;
  endtask

  task automatic test_glitch();
    logic [31:0] d; logic e, r;
    @(negedge clock); ps2_clk = 1'b0;
    @(negedge clock); ps2_clk = 1'b1;
    waitClk(20);
    @(negedge clock); ps2_clk = 1'b0;
    waitClk(3); ps2_clk = 1'b1;
    waitClk(20);
    sendFrame(8'h33, 0, 0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0101) begin testsFailed++; $display("[TB] FAIL glitch_status got %h want 0101", d); end
    apbRead(32'h0, d, e, r); void'(modelPop()); testsRun++;
    if (d !== 32'h133) begin testsFailed++; $display("[TB] FAIL glitch_data got %h want 133", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic e, r;
    apbRead(32'hC, d, e, r); testsRun++;
    if (e !== 1'b1 || r !== 1'b1 || d !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL unmapped_read err=%b rdy=%b data=%h want 1/1/0", e, r, d);
    end
    apbWrite(32'hC, 32'hFFFF_FFFF, 4'hF);
    apbRead(32'h8, d, e, r); testsRun++;
    if (d !== 32'h1 || e !== 1'b0) begin testsFailed++; $display("[TB] FAIL unmapped_write ctrl=%h err=%b want 1/0", d, e); end
  endtask

  task automatic test_disable();
    logic [31:0] d; logic e, r;
    apbWrite(32'h8, 32'h0, 4'h1); modelEn = 0;
    sendFrame(8'h42, 0, 0);
    apbWrite(32'h8, 32'h1, 4'h0);
    apbRead(32'h8, d, e, r); testsRun++;
    if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL disable_ctrl got %h want 0", d); end
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== expStatus()) begin testsFailed++; $display("[TB] FAIL disable_status got %h want %h", d, expStatus()); end
    apbWrite(32'h8, 32'h1, 4'h1); modelEn = 1;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic e, r;
    sendFrame(8'h99, 0, 0);
    sendBits(makeFrame(8'hC3, 0, 0), 5);
    doReset();
    sendFrame(8'h77, 0, 0);
    apbRead(32'h4, d, e, r); testsRun++;
    if (d !== 32'h0101) begin testsFailed++; $display("[TB] FAIL midreset_status got %h want 0101", d); end
    apbRead(32'h0, d, e, r); void'(modelPop()); testsRun++;
    if (d !== 32'h177) begin testsFailed++; $display("[TB] FAIL midreset_data got %h want 177", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, x; logic e, r;
    logic [7:0] b; int kind;
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      sendFrame(b, kind == 0, kind == 1);
      if ($urandom_range(0, 2) == 0) begin
        apbRead(32'h0, d, e, r); x = modelPop(); testsRun++;
        if (d !== x) begin testsFailed++; $display("[TB] FAIL rand_data%0d got %h want %h", i, d, x); end
      end
      apbRead(32'h4, d, e, r); testsRun++;
      if (d !== expStatus()) begin testsFailed++; $display("[TB] FAIL rand_status%0d got %h want %h", i, d, expStatus()); end
    end
    while (modelQ.size() != 0) begin
      apbRead(32'h0, d, e, r); x = modelPop(); testsRun++;
      if (d !== x) begin testsFailed++; $display("[TB] FAIL rand_drain got %h want %h", d, x); end
    end
  endtask

  initial begin
    bus.in_paddr = 32'd0; bus.in_psel = 1'b0; bus.in_penable = 1'b0; bus.in_pprot = 3'd0;
    bus.in_pwrite = 1'b0; bus.in_pwdata = 32'd0; bus.in_pstrb = 4'h0;
    doReset();
    test_reset();
    test_single();
    test_irq();
    test_overflow();
    test_parity();
    test_timeout();
    test_glitch();
    test_unmapped();
    test_disable();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
